pipelined_fetch: RTL and testbench

PIPELINED_FETCH -- requirements
Module: pipelined_fetch

---
 rtl/pipelined_fetch.sv | 106 ++++++++++
 tb/tb_pipelined_fetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_fetch.sv
// Instruction fetch front end: issues one read per cycle from a PC register and
// buffers returned instructions in a small circular queue for decode.
module pipelined_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int            AW      = $clog2(QDEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] fpc_r;
    logic [XLEN-1:0] req_pc_r;
    logic            inflight_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [CW:0]     occupancy_s;
    logic            push_s;
    logic            pop_s;

    logic [XLEN-1:0] pc_q_r    [QDEPTH];
    logic [XLEN-1:0] instr_q_r [QDEPTH];

    // Slots already promised to an outstanding read count as occupied; pops do not free space early.
    assign occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    assign imem_req     = !redirect_valid && (occupancy_s < DEPTH_W);
    assign imem_addr    = fpc_r;

    // A response arriving alongside a redirect belongs to the squashed path.
    assign push_s       = inflight_r && !redirect_valid;
    assign pop_s        = out_valid && out_ready;

    assign out_valid    = (count_r != {CW{1'b0}});
    assign q_count      = count_r;
    assign out_pc       = pc_q_r[rd_ptr_r];
    assign out_instr    = instr_q_r[rd_ptr_r];
    assign out_pc_plus4 = out_pc + XLEN'(32'd4);

    // Next occupancy for the current push/pop combination
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Fetch PC, outstanding-request tracking and queue pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_r      <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
            inflight_r <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            inflight_r <= imem_req;
            if (redirect_valid) begin
                fpc_r    <= {redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                count_r  <= {CW{1'b0}};
            end else begin
                if (imem_req) begin
                    fpc_r    <= fpc_r + XLEN'(32'd4);
                    req_pc_r <= fpc_r;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
                count_r <= count_nxt_s;
            end
        end
    end

    // Queue payload storage; contents are only meaningful below count_r
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_q_r[wr_ptr_r]    <= req_pc_r;
            instr_q_r[wr_ptr_r] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pipelined_fetch.sv
// Directed bench for pipelined_fetch: memory returns the word equal to its address,
// so every queued instruction must equal its PC.
module tb_pipelined_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc, out_pc_plus4, out_instr;
    logic [2:0]  q_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_pc, w_pc4, w_instr;
    logic [2:0]  w_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_fetch dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .q_count(q_count)
    );

    pipelined_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_pc),
        .out_pc_plus4(w_pc4), .out_instr(w_instr), .q_count(w_cnt)
    );

    // Memory models: one-cycle read latency, garbage when no request was made
    always @(posedge clk) begin
        imem_rdata <= (imem_req && rst) ? imem_addr : 32'hDEAD_BEEF;
        w_rdata    <= (w_req && rst) ? w_addr : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [2:0]  cnt;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rp,
                                input logic rdy, input logic rq, input logic [31:0] a,
                                input logic v, input logic [2:0] c, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.redir = rv; t.rpc = rp; t.ready = rdy;
        t.req = rq; t.addr = a; t.valid = v; t.cnt = c; t.pc = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        out_ready      = v.ready;
        #1;
        if (v.rst) check("imem_req", 32'(imem_req), 32'(v.req));
        check("imem_addr", imem_addr, v.addr);
        check("out_valid", 32'(out_valid), 32'(v.valid));
        check("q_count", 32'(q_count), 32'(v.cnt));
        if (v.valid) begin
            check("out_pc", out_pc, v.pc);
            check("out_instr", out_instr, v.pc);
            check("out_pc_plus4", out_pc_plus4, v.pc + 32'd4);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #1;
        check("reset_count", 32'(q_count), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_addr", imem_addr, 32'h0);

        // Streaming from release, then reset, then back-pressure and refill
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 3'd0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 3'd0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 3'd1, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 3'd1, 32'h04));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 3'd1, 32'h08));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 3'd0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 3'd0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b0, 3'd0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b1, 3'd1, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0C, 1'b1, 3'd2, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 3'd3, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 3'd4, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 3'd4, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 3'd4, 32'h00));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 3'd3, 32'h04));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 3'd2, 32'h08));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 1'b1, 3'd2, 32'h0C));
        tbl.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 1'b1, 3'd2, 32'h10));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Redirect to 0x103 with three queued and one read outstanding
        apply(mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h008, 1'b1, 3'd1, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 1'b1, 3'd2, 32'h0));
        apply(mk(1'b1, 1'b1, 32'h103, 1'b0, 1'b0, 32'h010, 1'b1, 3'd3, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 3'd1, 32'h100));

        // Back-to-back redirects: only 0x80 may be fetched
        apply(mk(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h10C, 1'b1, 3'd2, 32'h100));
        apply(mk(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h040, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h080, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h084, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h088, 1'b1, 3'd1, 32'h080));
        apply(mk(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08C, 1'b1, 3'd2, 32'h080));

        // Asynchronous reset with two queued; stale read data must not be pushed
        apply(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 3'd0, 32'h0));
        apply(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 3'd1, 32'h0));

        // Address wrap-around on the second instance after a fresh release
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        check("wrap_first_req", 32'(w_req), 32'd1);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("wrap_valid_early", 32'(w_valid), 32'd0);
        @(negedge clk); #1;
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", w_instr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc1_plus4", w_pc4, 32'h0000_0000);
        @(negedge clk); #1;
        check("wrap_pc2", w_pc, 32'h0000_0000);
        check("wrap_instr2", w_instr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
